// File: rtl/xor_nn_pkg.sv
// Shared definitions for the XOR 2-2-1 network blocks: word format defaults,
// weight index map, training FSM states and the last step of the update schedule.
package xor_nn_pkg;

    localparam int DEFAULT_DATA_W = 17;
    localparam int DEFAULT_FRAC_W = 12;
    localparam int N_WEIGHTS      = 9;

    localparam logic [3:0] W11 = 4'd0;
    localparam logic [3:0] W12 = 4'd1;
    localparam logic [3:0] B1  = 4'd2;
    localparam logic [3:0] W21 = 4'd3;
    localparam logic [3:0] W22 = 4'd4;
    localparam logic [3:0] B2  = 4'd5;
    localparam logic [3:0] WO1 = 4'd6;
    localparam logic [3:0] WO2 = 4'd7;
    localparam logic [3:0] BO  = 4'd8;

    localparam logic [4:0] LAST_STEP = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/xor_nn_fxmul.sv
// Fixed-point multiplier: full signed product, arithmetic shift by FRAC_W, narrow to DATA_W.
// With XOR_NN_BACKPROP_SAT_EN defined the narrowing saturates; otherwise it wraps.
module xor_nn_fxmul
    import xor_nn_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int FRAC_W = DEFAULT_FRAC_W
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] p_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] shifted;

    assign prod    = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
    assign shifted = prod >>> FRAC_W;

`ifdef XOR_NN_BACKPROP_SAT_EN
    localparam logic signed [2*DATA_W-1:0] P_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] P_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    always_comb begin
        if (shifted > P_MAX) begin
            p_o = DATA_W'(P_MAX);
        end else if (shifted < P_MIN) begin
            p_o = DATA_W'(P_MIN);
        end else begin
            p_o = DATA_W'(shifted);
        end
    end
`else
    assign p_o = DATA_W'(shifted);
`endif

endmodule

// File: rtl/xor_nn_backprop.sv
// Backward pass plus one SGD step for the 2-2-1 sigmoid XOR network, 9 weights held locally.
// Build option XOR_NN_BACKPROP_SAT_EN: saturating narrowing instead of two's-complement wrap.
module xor_nn_backprop
    import xor_nn_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int FRAC_W = DEFAULT_FRAC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [DATA_W-1:0]   x1,
    input  logic signed [DATA_W-1:0]   x2,
    input  logic signed [DATA_W-1:0]   target,
    input  logic signed [DATA_W-1:0]   h1,
    input  logic signed [DATA_W-1:0]   h2,
    input  logic signed [DATA_W-1:0]   y,
    input  logic signed [DATA_W-1:0]   lr,
    input  logic                       w_load,
    input  logic [3:0]                 w_addr,
    input  logic signed [DATA_W-1:0]   w_data,
    output logic [9*DATA_W-1:0]        weights,
    output logic                       busy,
    output logic                       done,
    output logic signed [DATA_W-1:0]   delta_o,
    output state_e                     state_dbg_o
);

    // Handshake: start is a one-cycle request taken only in IDLE (a same-edge w_load lands
    // first); busy spans CALC..DONE, and done pulses for one cycle once weights are final.

    typedef struct packed {
        logic signed [DATA_W-1:0] x1;
        logic signed [DATA_W-1:0] x2;
        logic signed [DATA_W-1:0] tgt;
        logic signed [DATA_W-1:0] h1;
        logic signed [DATA_W-1:0] h2;
        logic signed [DATA_W-1:0] y;
        logic signed [DATA_W-1:0] lr;
    } sample_t;

    // q and r are reused by both hidden neurons; g carries g, g1 and g2 in turn.
    typedef struct packed {
        logic signed [DATA_W-1:0] p;
        logic signed [DATA_W-1:0] q;
        logic signed [DATA_W-1:0] r;
        logic signed [DATA_W-1:0] d1;
        logic signed [DATA_W-1:0] d2;
        logic signed [DATA_W-1:0] g;
        logic signed [DATA_W-1:0] delta;
    } tmp_t;

    localparam logic signed [DATA_W-1:0] ONE = {{(DATA_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

`ifdef XOR_NN_BACKPROP_SAT_EN
    localparam logic signed [DATA_W:0] S_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0] S_MIN = {2'b11, {(DATA_W-1){1'b0}}};
`endif

    state_e                   state_q, state_d;
    logic [4:0]               step_q, step_d;
    sample_t                  smp_q, smp_d;
    tmp_t                     tmp_q, tmp_d;
    logic signed [DATA_W-1:0] w_q [N_WEIGHTS];
    logic signed [DATA_W-1:0] w_d [N_WEIGHTS];
    logic signed [DATA_W-1:0] mul_a, mul_b, mul_p;

    function automatic logic signed [DATA_W-1:0] sub_n(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
`ifdef XOR_NN_BACKPROP_SAT_EN
        if (s > S_MAX) return DATA_W'(S_MAX);
        if (s < S_MIN) return DATA_W'(S_MIN);
`endif
        return DATA_W'(s);
    endfunction

    xor_nn_fxmul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (
        .a_i(mul_a),
        .b_i(mul_b),
        .p_o(mul_p)
    );

    // Operand schedule; hidden deltas read wo1/wo2 before steps 9-10 overwrite them.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step_q)
            5'd0:  begin mul_a = smp_q.y;                  mul_b = sub_n(ONE, smp_q.y);  end
            5'd1:  begin mul_a = sub_n(smp_q.y, smp_q.tgt); mul_b = tmp_q.p;             end
            5'd2:  begin mul_a = smp_q.h1;                 mul_b = sub_n(ONE, smp_q.h1); end
            5'd3:  begin mul_a = tmp_q.delta;              mul_b = w_q[WO1];             end
            5'd4:  begin mul_a = tmp_q.r;                  mul_b = tmp_q.q;              end
            5'd5:  begin mul_a = smp_q.h2;                 mul_b = sub_n(ONE, smp_q.h2); end
            5'd6:  begin mul_a = tmp_q.delta;              mul_b = w_q[WO2];             end
            5'd7:  begin mul_a = tmp_q.r;                  mul_b = tmp_q.q;              end
            5'd8:  begin mul_a = smp_q.lr;                 mul_b = tmp_q.delta;          end
            5'd9:  begin mul_a = tmp_q.g;                  mul_b = smp_q.h1;             end
            5'd10: begin mul_a = tmp_q.g;                  mul_b = smp_q.h2;             end
            5'd11: begin mul_a = smp_q.lr;                 mul_b = tmp_q.d1;             end
            5'd12: begin mul_a = tmp_q.g;                  mul_b = smp_q.x1;             end
            5'd13: begin mul_a = tmp_q.g;                  mul_b = smp_q.x2;             end
            5'd14: begin mul_a = smp_q.lr;                 mul_b = tmp_q.d2;             end
            5'd15: begin mul_a = tmp_q.g;                  mul_b = smp_q.x1;             end
            5'd16: begin mul_a = tmp_q.g;                  mul_b = smp_q.x2;             end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        smp_d   = smp_q;
        tmp_d   = tmp_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (w_load && (w_addr < 4'd9)) begin
                    w_d[w_addr] = w_data;
                end
                if (start) begin
                    smp_d   = '{x1: x1, x2: x2, tgt: target, h1: h1, h2: h2, y: y, lr: lr};
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                case (step_q)
                    5'd0:               tmp_d.p     = mul_p;
                    5'd1:               tmp_d.delta = mul_p;
                    5'd2, 5'd5:         tmp_d.q     = mul_p;
                    5'd3, 5'd6:         tmp_d.r     = mul_p;
                    5'd4:               tmp_d.d1    = mul_p;
                    5'd7:               tmp_d.d2    = mul_p;
                    5'd8, 5'd11, 5'd14: tmp_d.g     = mul_p;
                    5'd9: begin
                        w_d[WO1] = sub_n(w_q[WO1], mul_p);
                        w_d[BO]  = sub_n(w_q[BO], tmp_q.g);
                    end
                    5'd10: w_d[WO2] = sub_n(w_q[WO2], mul_p);
                    5'd12: begin
                        w_d[W11] = sub_n(w_q[W11], mul_p);
                        w_d[B1]  = sub_n(w_q[B1], tmp_q.g);
                    end
                    5'd13: w_d[W12] = sub_n(w_q[W12], mul_p);
                    5'd15: begin
                        w_d[W21] = sub_n(w_q[W21], mul_p);
                        w_d[B2]  = sub_n(w_q[B2], tmp_q.g);
                    end
                    5'd16: w_d[W22] = sub_n(w_q[W22], mul_p);
                    default: ;
                endcase
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q + 5'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            smp_q   <= '0;
            tmp_q   <= '0;
            for (int i = 0; i < N_WEIGHTS; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            smp_q   <= smp_d;
            tmp_q   <= tmp_d;
            w_q     <= w_d;
        end
    end

    for (genvar i = 0; i < N_WEIGHTS; i++) begin : g_weights
        assign weights[i*DATA_W +: DATA_W] = w_q[i];
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign delta_o     = tmp_q.delta;
    assign state_dbg_o = state_q;

endmodule
